// File: rtl/node_info_streamer_if.sv
// node_info_streamer_if: per-node descriptor stream with valid/ready handshake
interface node_info_streamer_if #(
  parameter int ROW_LEN_WIDTH  = 5,
  parameter int NUM_NODE_WIDTH = 5,
  parameter int H_DATA_ADDR_W  = 11,
  parameter int SG_IDX_W       = 4
);
  logic                      valid;
  logic                      ready;
  logic [ROW_LEN_WIDTH-1:0]  row_length;
  logic [NUM_NODE_WIDTH-1:0] num_nodes;
  logic [NUM_NODE_WIDTH-1:0] node_idx;
  logic                      is_source;
  logic                      is_last;
  logic [SG_IDX_W-1:0]       sg_idx;
  logic [H_DATA_ADDR_W-1:0]  h_base;
  modport master (output valid, row_length, num_nodes, node_idx, is_source, is_last, sg_idx, h_base, input ready);
  modport slave (input valid, row_length, num_nodes, node_idx, is_source, is_last, sg_idx, h_base, output ready);
endinterface

// File: rtl/node_info_streamer.sv
// node_info_streamer: walks node-info BRAM records and streams decoded per-node descriptors
module node_info_streamer #(
  parameter int ROW_LEN_WIDTH    = 5,
  parameter int NUM_NODE_WIDTH   = 5,
  parameter int NODE_INFO_ADDR_W = 7,
  parameter int H_DATA_ADDR_W    = 11,
  parameter int SG_IDX_W         = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [NODE_INFO_ADDR_W:0]                 total_nodes,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      ni_en,
  output logic [NODE_INFO_ADDR_W-1:0]               ni_addr,
  input  logic [ROW_LEN_WIDTH+NUM_NODE_WIDTH:0]     ni_dout,
  node_info_streamer_if.master                      out,
  output logic                                      err_framing
);
  localparam int NODE_INFO_WIDTH = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  typedef logic [NODE_INFO_ADDR_W:0] cnt_t;
  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0]  row_length;
    logic [NUM_NODE_WIDTH-1:0] num_nodes;
    logic [NUM_NODE_WIDTH-1:0] node_idx;
    logic                      is_source;
    logic                      is_last;
    logic [SG_IDX_W-1:0]       sg_idx;
    logic [H_DATA_ADDR_W-1:0]  h_base;
  } desc_t;

  state_t                    state_q, state_d;
  cnt_t                      tot_q, tot_d;
  logic [NODE_INFO_ADDR_W-1:0] addr_q, addr_d;
  logic                      rv_q;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      expect_q, expect_d;
  logic                      first_q, first_d;
  logic [NUM_NODE_WIDTH-1:0] size_q, size_d;
  logic [NUM_NODE_WIDTH-1:0] idx_q, idx_d;
  logic [SG_IDX_W-1:0]       sg_q, sg_d;
  logic [H_DATA_ADDR_W-1:0]  acc_q, acc_d;
  desc_t                     mem_q [2];
  desc_t                     mem_d [2];
  logic                      wp_q, wp_d, rp_q, rp_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      pop, go, last_issue, flag, new_sg;
  logic [ROW_LEN_WIDTH-1:0]  row;
  logic [NUM_NODE_WIDTH-1:0] num;
  desc_t                     desc;

  assign out.valid = cnt_q != 2'd0;
  assign {out.row_length, out.num_nodes, out.node_idx, out.is_source, out.is_last, out.sg_idx, out.h_base} = mem_q[rp_q];
  assign pop = out.valid && out.ready;
  // A read may issue only if the FIFO can still hold it, counting the return already in flight.
  assign ni_en = state_q == FETCH && (3'(cnt_q) + 3'(rv_q) - 3'(pop) < 3'd2);
  assign ni_addr = addr_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err_framing = err_q;
  assign go = start && state_q == IDLE;
  assign last_issue = ni_en && (cnt_t'(addr_q) + cnt_t'(1) == tot_q);
  assign row = ni_dout[NODE_INFO_WIDTH-1 -: ROW_LEN_WIDTH];
  assign num = ni_dout[NUM_NODE_WIDTH:1];
  assign flag = ni_dout[0];
  assign new_sg = expect_q || flag;

  // Next-state: control, address walk, record decode into the FIFO, FIFO pointers.
  always_comb begin
    state_d = state_q;
    tot_d = tot_q;
    addr_d = addr_q;
    done_d = 1'b0;
    err_d = err_q;
    expect_d = expect_q;
    first_d = first_q;
    size_d = size_q;
    idx_d = idx_q;
    sg_d = sg_q;
    acc_d = acc_q;
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = pop ? !rp_q : rp_q;
    cnt_d = cnt_q + 2'(rv_q) - 2'(pop);
    desc = '0;
    if (go) begin
      tot_d = total_nodes;
      err_d = 1'b0;
      done_d = total_nodes == '0;
      state_d = total_nodes == '0 ? IDLE : FETCH;
      addr_d = '0;
      expect_d = 1'b1;
      first_d = 1'b1;
      size_d = '0;
      idx_d = '0;
      sg_d = '0;
      acc_d = '0;
      wp_d = 1'b0;
      rp_d = 1'b0;
      cnt_d = 2'd0;
    end
    if (ni_en) begin
      addr_d = last_issue ? addr_q : addr_q + NODE_INFO_ADDR_W'(1);
      state_d = last_issue ? DRAIN : FETCH;
    end
    if (rv_q) begin
      size_d = new_sg ? (num == '0 ? NUM_NODE_WIDTH'(1) : num) : size_q;
      idx_d = new_sg ? '0 : idx_q + NUM_NODE_WIDTH'(1);
      sg_d = new_sg ? (first_q ? '0 : sg_q + SG_IDX_W'(1)) : sg_q;
      first_d = first_q && !new_sg;
      desc = '{row, size_d, idx_d, new_sg, idx_d == size_d - NUM_NODE_WIDTH'(1), sg_d, acc_q};
      expect_d = desc.is_last;
      acc_d = acc_q + H_DATA_ADDR_W'(row);
      err_d = err_q || (flag ^ expect_q) || (new_sg && num == '0);
      mem_d[wp_q] = desc;
      wp_d = !wp_q;
    end
    if (state_q == DRAIN && cnt_q == 2'd1 && pop && !rv_q) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end

  // State registers; the read-valid flop drops any BRAM return in flight at reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tot_q <= '0;
      addr_q <= '0;
      rv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      expect_q <= 1'b1;
      first_q <= 1'b1;
      size_q <= '0;
      idx_q <= '0;
      sg_q <= '0;
      acc_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      tot_q <= tot_d;
      addr_q <= addr_d;
      rv_q <= ni_en;
      done_q <= done_d;
      err_q <= err_d;
      expect_q <= expect_d;
      first_q <= first_d;
      size_q <= size_d;
      idx_q <= idx_d;
      sg_q <= sg_d;
      acc_q <= acc_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_node_info_streamer.sv
// tb_node_info_streamer: directed and randomized checks against a record-level reference model
module tb_node_info_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [7:0] total = 8'd0;
  logic busy, done, ni_en, err, busy2, done2, ni_en2, err2;
  logic [6:0] ni_addr, ni_addr2;
  logic [10:0] ni_dout = '0;
  logic [10:0] ni_dout2 = '0;
  logic [10:0] mem [128];
  int checks = 0;
  int failures = 0;

  node_info_streamer_if ifc ();
  node_info_streamer_if #(.H_DATA_ADDR_W(4)) ifw ();

  node_info_streamer u_dut (
    .clk(clk), .rst(rst), .start(start), .total_nodes(total), .busy(busy), .done(done),
    .ni_en(ni_en), .ni_addr(ni_addr), .ni_dout(ni_dout), .out(ifc), .err_framing(err)
  );

  node_info_streamer #(.H_DATA_ADDR_W(4)) u_w (
    .clk(clk), .rst(rst), .start(start2), .total_nodes(8'd3), .busy(busy2), .done(done2),
    .ni_en(ni_en2), .ni_addr(ni_addr2), .ni_dout(ni_dout2), .out(ifw), .err_framing(err2)
  );

  assign ifw.ready = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ni_en) ni_dout <= mem[ni_addr];
    if (ni_en2) ni_dout2 <= mem[ni_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_desc();
    return {ifc.row_length, ifc.num_nodes, ifc.node_idx, ifc.is_source, ifc.is_last, ifc.sg_idx, ifc.h_base};
  endfunction

  // Random well-formed subgraphs, optionally with a few framing faults planted.
  task automatic fill(input int n, input bit corrupt, input int rmin);
    int i = 0;
    while (i < n) begin
      int s = $urandom_range(1, 5);
      for (int j = 0; j < s && i < n; j++) begin
        mem[i] = {5'($urandom_range(rmin, 31)), j == 0 ? 5'(s) : 5'($urandom), j == 0};
        i++;
      end
    end
    if (corrupt) for (int k = 0; k < 3; k++) begin
      int p = $urandom_range(0, n - 1);
      if ($urandom_range(0, 1) == 1) mem[p][0] = ~mem[p][0];
      else mem[p][5:1] = 5'd0;
    end
  endtask

  // mode: 0 ready always high, 1 ready toggling, 2 ready random
  task automatic run(input int n, input int mode);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int exp_src = 1, sg = -1, size = 0, idx = 0, acc = 0, first_err = -1;
    int iss = 0, pops = 0, done_c = -1, err_c = -1, fv_c = -1;
    logic [4:0] row, num;
    logic flag, src, last;
    for (int i = 0; i < n; i++) begin
      {row, num, flag} = mem[i];
      if ((flag != exp_src[0] || ((flag || exp_src != 0) && num == 5'd0)) && first_err < 0) first_err = i;
      src = flag || exp_src != 0;
      if (src) begin
        sg++;
        size = num == 5'd0 ? 1 : int'(num);
        idx = 0;
      end else idx++;
      last = idx == size - 1;
      exp_q.push_back({row, 5'(size), 5'(idx), src, last, 4'(sg), 11'(acc)});
      acc += int'(row);
      exp_src = int'(last);
    end
    @(posedge clk);
    #1 start = 1'b1;
    total = n[7:0];
    ifc.ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40 * n + 20 && done_c < 0; c++) begin
      ifc.ready = mode == 0 ? 1'b1 : mode == 1 ? c[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 1) begin
        chk("busy_c1", busy, n > 0);
        chk("err_clear", err, 0);
      end
      if (ni_en) begin
        chk("ni_addr", ni_addr, iss);
        iss++;
      end
      if (ifc.valid && fv_c < 0) fv_c = c;
      if (ifc.valid && ifc.ready) begin
        got_q.push_back(cur_desc());
        pops++;
      end
      if (err && err_c < 0) err_c = c;
      chk("occupancy", iss - pops <= 2, 1);
      if (done) begin
        done_c = c;
        chk("busy_at_done", busy, 0);
      end
      @(posedge clk);
      #1;
    end
    chk("done_seen", done_c > 0, 1);
    if (mode == 0) chk("done_cycle", done_c, n == 0 ? 1 : n + 3);
    if (mode == 0 && n > 0) chk("first_valid", fv_c, 3);
    if (mode == 0 && first_err >= 0) chk("err_rise", err_c, first_err + 3);
    chk("reads", iss, n);
    chk("desc_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk($sformatf("desc[%0d]", i), got_q[i], exp_q[i]);
    chk("err_final", err, first_err >= 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_ni_en", ni_en, 0);
  endtask

  initial begin
    int wexp [3] = '{0, 15, 14};
    int k;
    ifc.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ni_en", ni_en, 0);
    chk("rst_ni_addr", ni_addr, 0);
    chk("rst_valid", ifc.valid, 0);
    chk("rst_err", err, 0);
    chk("rst_desc", cur_desc(), 0);
    rst = 1'b0;

    mem[0] = {5'd3, 5'd3, 1'b1};
    mem[1] = {5'd2, 5'd3, 1'b0};
    mem[2] = {5'd4, 5'd3, 1'b0};
    mem[3] = {5'd5, 5'd2, 1'b1};
    mem[4] = {5'd1, 5'd2, 1'b0};
    run(5, 0);
    run(5, 1);
    run(0, 0);

    mem[0] = {5'd2, 5'd3, 1'b1};
    mem[1] = {5'd2, 5'd3, 1'b1};
    run(2, 0);

    fill(10, 1'b0, 0);
    @(posedge clk);
    #1 start = 1'b1;
    total = 8'd10;
    ifc.ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ni_en", ni_en, 0);
    chk("arst_ni_addr", ni_addr, 0);
    chk("arst_valid", ifc.valid, 0);
    chk("arst_err", err, 0);
    chk("arst_desc", cur_desc(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(10, 0);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 40);
      fill(n, 1'($urandom_range(0, 1)), 0);
      run(n, $urandom_range(0, 2));
    end
    fill(120, 1'b0, 25);
    run(120, 2);

    mem[0] = {5'd15, 5'd1, 1'b1};
    mem[1] = {5'd15, 5'd1, 1'b1};
    mem[2] = {5'd1, 5'd1, 1'b1};
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    k = 0;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      if (ifw.valid && k < 3) begin
        chk($sformatf("wrap_h[%0d]", k), 32'(ifw.h_base), wexp[k]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    chk("wrap_count", k, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/node_info_streamer.md
# node_info_streamer

Sequential fetcher/decoder for the node-info BRAM: walks `total_nodes` packed records and unpacks each into row length, subgraph size and source flag. Tracks subgraph framing and emits a per-node descriptor stream with backpressure, including the running H-data base address (prefix sum of row lengths). Sits between the node-info BRAM and the sparse H·W scheduler. It is the parametrised, runtime-sized successor of the static per-dataset node-info layout.

## Interface
Parameters:
- `ROW_LEN_WIDTH`, 5: width of the row_length field.
- `NUM_NODE_WIDTH`, 5: width of the num_of_nodes field and of node index.
- `NODE_INFO_ADDR_W`, 7: BRAM address width.
- `H_DATA_ADDR_W`, 11: width of the H-data base address.
- `SG_IDX_W`, 4: subgraph index width.
- Derived `NODE_INFO_WIDTH` = ROW_LEN_WIDTH+NUM_NODE_WIDTH+1. Record layout, MSB→LSB: {row_length, num_of_nodes, source_node_flag}.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `start`  in  1  single-cycle; accepted only when idle.
- `total_nodes`  in  NODE_INFO_ADDR_W+1  record count; sampled on an accepted start.
- `busy`  out  1  high from an accepted start until done.
- `done`  out  1  single-cycle pulse.
- `ni_en`  out  1  BRAM read enable.
- `ni_addr`  out  NODE_INFO_ADDR_W  BRAM read address.
- `ni_dout`  in  NODE_INFO_WIDTH  BRAM data, valid exactly 1 cycle after `ni_en`.
- `out_valid` / `out_ready`  out/in  1  descriptor handshake.
- `out_row_length`  out  ROW_LEN_WIDTH.
- `out_num_nodes`  out  NUM_NODE_WIDTH  size of the current subgraph.
- `out_node_idx`  out  NUM_NODE_WIDTH  index within the subgraph; the source node is 0.
- `out_is_source`, `out_is_last`  out  1  first / last node of the subgraph.
- `out_sg_idx`  out  SG_IDX_W  subgraph ordinal, wraps modulo 2^SG_IDX_W.
- `out_h_base`  out  H_DATA_ADDR_W  sum of all previous row_lengths, wraps modulo 2^H_DATA_ADDR_W.
- `err_framing`  out  1  sticky; cleared by rst or an accepted start.

## Operation
- States: IDLE, FETCH, DRAIN.
- **IDLE**
  - An accepted start with total_nodes>0 clears the read address, node/subgraph counters, h_base accumulator, the FIFO and `err_framing`, then goes to FETCH.
  - An accepted start with total_nodes=0 pulses `done` the next cycle and stays IDLE. No reads are issued.
- **FETCH**
  - Issues reads at addresses 0..total_nodes-1 in order.
  - A read is issued in a cycle only if (fifo_count + inflight − pop_this_cycle) < 2.
  - The output FIFO is 2 deep. This gives 1 descriptor/cycle sustained with `out_ready` held high, and no overflow under any `out_ready` pattern.
  - After the last read issues, go to DRAIN.
- **DRAIN**
  - When the last descriptor is popped, pulse `done` the following cycle and return to IDLE.
- **Decode** (on BRAM return, before FIFO write):
  - Expecting a source, flag=1: start a new subgraph. size = num_of_nodes, node_idx=0, is_source=1. sg_idx increments, except for the first subgraph, which is 0.
  - Mid-subgraph, flag=0: node_idx+1, with size and sg_idx inherited.
  - is_last = (node_idx == size−1).
  - h_base = accumulator. Then accumulator += row_length.
- **Framing errors.** Each sets `err_framing`; the descriptor is still emitted.
  - flag=1 mid-subgraph: resynchronise, treating the record as a new source.
  - flag=0 when a source is expected: treat it as a source of size num_of_nodes anyway.
  - Source with num_of_nodes=0: treat as size 1.
- `start` while busy is ignored.
- `rst` mid-operation aborts everything immediately. A BRAM return in flight at reset is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `ni_en`=0, `ni_addr`=0, `out_valid`=0, `err_framing`=0. All descriptor fields are 0.
- Start accepted at cycle 0:
  - `busy` and first `ni_en` at cycle 1.
  - `ni_dout` at cycle 2.
  - First `out_valid` at cycle 3.
- Descriptor fields are stable while out_valid && !out_ready.
- Pop occurs on out_valid && out_ready.
- N records with `out_ready` always high:
  - last descriptor at cycle N+2;
  - `done` at cycle N+3;
  - `busy` falls in the same cycle as `done`.
- `ni_addr` never exceeds total_nodes−1. `ni_en` is low in IDLE and DRAIN.

## Test plan
- Clean framing: records {3,3,1},{2,3,0},{4,3,0},{5,2,1},{1,2,0}, out_ready=1:
  - h_base 0,3,5,9,14;
  - node_idx 0,1,2,0,1;
  - is_last on records 2 and 4;
  - sg_idx 0,0,0,1,1;
  - `done` at cycle 8; `err_framing`=0.
- Backpressure: the same records with out_ready toggling 1/0 each cycle. Descriptors are identical and in order, with no drop or duplicate, and ni_en never overflows the FIFO.
- total_nodes=0: `done` at cycle 1, `ni_en` never asserted, `busy` stays 0.
- Framing errors: {2,3,1},{2,3,1} (source mid-subgraph).
  - Second descriptor has node_idx=0, sg_idx=1.
  - `err_framing`=1 from its FIFO write onward; cleared by the next start.
- Reset mid-FETCH: rst asserted at cycle 4 of a 10-node run.
  - All outputs return to reset values asynchronously.
  - A new start yields a full correct run from address 0.
- Wrap: H_DATA_ADDR_W=4 with row_lengths 15,15 → h_base 0, then 15; accumulator wraps to 14.
